// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: computes a - b - bin over WIDTH bits, one bit per
//   clock, LSB first, through a single full-subtract cell and a borrow flop.
//   Results are registered and held stable until the next operation ends.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only in IDLE or DONE
//   a, b   minuend / subtrahend, captured on an accepted start
//   bin    borrow in, captured on an accepted start
//   busy   high while an operation is in progress
//   done   one-cycle pulse when a result is written
//   diff   registered difference (a - b - bin) mod 2^WIDTH
//   bout   registered borrow out (unsigned a < b + bin)
//   ovf    registered two's-complement overflow
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Full-subtract cell on the current LSBs.
  logic d_bit;
  logic br_next;

  always_comb begin
    d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          sd_d    = '0;
          br_d    = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sd_d = {d_bit, sd_q[WIDTH-1:1]};
        br_d = br_next;
        if (cnt_q == LAST) begin
          // br_q here is the borrow into the MSB, so overflow is the
          // disagreement between borrow-in and borrow-out of the top bit.
          diff_d  = {d_bit, sd_q[WIDTH-1:1]};
          bout_d  = br_next;
          ovf_d   = br_q ^ br_next;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: a WIDTH=8 and a WIDTH=4 instance checked
// every cycle against an arithmetic reference model, plus literal checks.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: result packed as {ovf, bout, diff[31:0]}.
  function automatic logic [33:0] ref_sub(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic bin);
    longint ua, ub, full, sa, sb, sr, half, mask;
    logic [33:0] r;
    ua   = longint'(a);
    ub   = longint'(b);
    mask = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    full = ua - ub - longint'(bin);
    sa   = (ua >= half) ? ua - (64'sd1 <<< w) : ua;
    sb   = (ub >= half) ? ub - (64'sd1 <<< w) : ub;
    sr   = sa - sb - longint'(bin);
    r          = '0;
    r[31:0]    = 32'(full & mask);
    r[32]      = (ua < ub + longint'(bin));
    r[33]      = (sr > half - 1) || (sr < -half);
    return r;
  endfunction

  // Behavioural model: index 0 is WIDTH=8, index 1 is WIDTH=4.
  bit          m_busy[2];
  bit          m_done[2];
  int          m_left[2];
  logic [33:0] m_pend[2];
  logic [33:0] m_res[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0; m_pend[k] = '0; m_res[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic st;
        st = (k == 0) ? start8 : start4;
        if (!m_busy[k]) begin
          m_done[k] = 0;
          if (st) begin
            m_busy[k] = 1;
            m_left[k] = (k == 0) ? 8 : 4;
            m_pend[k] = (k == 0) ? ref_sub(8, {24'b0, a8}, {24'b0, b8}, bin8)
                                 : ref_sub(4, {28'b0, a4}, {28'b0, b4}, bin4);
          end
        end else begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_busy[k] = 0;
            m_done[k] = 1;
            m_res[k]  = m_pend[k];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy8", 34'(busy8), 34'(m_busy[0]));
    chk("done8", 34'(done8), 34'(m_done[0]));
    chk("res8",  {ovf8, bout8, 24'b0, diff8}, m_res[0]);
    chk("busy4", 34'(busy4), 34'(m_busy[1]));
    chk("done4", 34'(done4), 34'(m_done[1]));
    chk("res4",  {ovf4, bout4, 28'b0, diff4}, m_res[1]);
  end

  // From the current negedge, advance until done8 is seen (bounded).
  task automatic wait_done8(output int cyc, output int bc);
    cyc = 0; bc = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) bc++;
      @(negedge clk);
      cyc++;
    end
    if (!done8) chk("timeout8", 34'(done8), 34'd1);
  endtask

  task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input logic [7:0] ed, input logic eb,
                      input logic eo);
    int cyc, bc;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    wait_done8(cyc, bc);
    chk({nm, "_lat"},  34'(cyc), 34'd8);
    chk({nm, "_busy"}, 34'(bc), 34'd8);
    chk({nm, "_res"},  {ovf8, bout8, 24'b0, diff8}, {eo, eb, 24'b0, ed});
    @(negedge clk);
    chk({nm, "_donefall"}, 34'(done8), 34'd0);
  endtask

  initial begin
    int cyc, bc;

    // Pin the reference model with hand-worked values.
    chk("pin_a", ref_sub(8, 32'h80, 32'h01, 1'b0), {1'b1, 1'b0, 32'h7F});
    chk("pin_b", ref_sub(8, 32'h7F, 32'hFF, 1'b0), {1'b1, 1'b1, 32'h80});
    chk("pin_c", ref_sub(4, 32'h0, 32'h0, 1'b1),   {1'b0, 1'b1, 32'hF});

    repeat (2) @(negedge clk);
    chk("rst_out8", {busy8, done8, bout8, ovf8, 22'b0, diff8}, '0);
    chk("rst_out4", {busy4, done4, bout4, ovf4, 26'b0, diff4}, '0);
    rst_n = 1'b1;

    run8("t_basic",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run8("t_neg",    8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run8("t_zero",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run8("t_ovf1",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run8("t_ovf2",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run8("t_bzero",  8'hC3, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0);
    run8("t_equal",  8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start during RUN is ignored; start during DONE chains immediately.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(cyc, bc);
    chk("ign_res", 34'(diff8), 34'h0F);
    a8 = 8'h20; b8 = 8'h02; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy", 34'({busy8, done8}), 34'b10);
    wait_done8(cyc, bc);
    chk("b2b_lat", 34'(cyc + 1), 34'd9);
    chk("b2b_res", 34'(diff8), 34'h1E);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out8", {busy8, done8, bout8, ovf8, 22'b0, diff8}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) cyc++;
    end
    chk("arst_nodone", 34'(cyc), 34'd0);
    run8("t_after", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

    // Random traffic on the 8-bit instance, checked by the model.
    repeat (400) begin
      @(negedge clk);
      start8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive 4-bit sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
          cyc = 0;
          while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
          end
          chk("lat4", 34'(cyc), 34'd4);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
